// File: rtl/array_row_mult_seq_pkg.sv
// Shared constants and state encoding for the sequential row-reuse multiplier.
package array_mult_pkg;
  localparam int ROW_W  = 8;
  localparam int CNT_W  = 3;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {IDLE, ROW, RESOLVE, DONE} state_t;
endpackage

// File: rtl/array_row_mult_seq_if.sv
// Operand/product handshake bundle for array_row_mult_seq.
interface array_row_mult_seq_if;
  import array_mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  a;
  logic [ROW_W-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product, busy);
endinterface

// File: rtl/array_row_mult_seq_row.sv
// One carry-save row of the array multiplier: each cell adds a&b to the incoming sum and carry bits.
module EightBitArrayRow
  import array_mult_pkg::*;
(
  input  logic [ROW_W-1:0] a_i,
  input  logic [ROW_W-1:0] b_i,
  input  logic [ROW_W-1:0] sum_i,
  input  logic [ROW_W-1:0] c_i,
  output logic [ROW_W-1:0] s_o,
  output logic [ROW_W-1:0] c_o
);
  for (genvar j = 0; j < ROW_W; j++) begin : g_cell
    assign {c_o[j], s_o[j]} = {1'b0, a_i[j] & b_i[j]} + {1'b0, sum_i[j]} + {1'b0, c_i[j]};
  end
endmodule

// File: rtl/array_row_mult_seq.sv
// Sequential 8x8 multiplier reusing one carry-save row per cycle, then one 8-bit resolve add.
// Optional `ZERO_BYPASS_EN: a zero operand skips straight to DONE with product 0.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// ROW     | folding partial-product row row_cnt_q into the carry-save pair
// RESOLVE | adding sum_q + car_q to form the upper product byte
// DONE    | product presented until out_ready
module array_row_mult_seq
  import array_mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  array_row_mult_seq_if.slave bus
);
  state_t            state_q;
  logic [ROW_W-1:0]  a_q, b_q, sum_q, car_q, low_q;
  logic [CNT_W-1:0]  row_cnt_q;
  logic [PROD_W-1:0] product_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [ROW_W-1:0]  row_s, row_c;

  EightBitArrayRow u_row (
    .a_i   (a_q),
    .b_i   ({ROW_W{b_q[row_cnt_q]}}),
    .sum_i (sum_q),
    .c_i   (car_q),
    .s_o   (row_s),
    .c_o   (row_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      car_q       <= '0;
      low_q       <= '0;
      row_cnt_q   <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            sum_q      <= '0;
            car_q      <= '0;
            low_q      <= '0;
            row_cnt_q  <= '0;
            in_ready_q <= 1'b0;
`ifdef ZERO_BYPASS_EN
            if (bus.a == '0 || bus.b == '0) begin
              product_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ROW;
            end
`else
            busy_q  <= 1'b1;
            state_q <= ROW;
`endif
          end
        end
        ROW: begin
          // Bit 0 of the row sum is final; the rest shifts down one weight for the next row.
          low_q[row_cnt_q] <= row_s[0];
          sum_q            <= {1'b0, row_s[ROW_W-1:1]};
          car_q            <= row_c;
          if (row_cnt_q == CNT_W'(ROW_W - 1)) begin
            state_q <= RESOLVE;
          end else begin
            row_cnt_q <= row_cnt_q + 1'b1;
          end
        end
        RESOLVE: begin
          product_q   <= {sum_q + car_q, low_q};
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_array_row_mult_seq.sv
// Self-checking bench for array_row_mult_seq: directed scenarios plus randomized pairs against a*b.
module tb_array_row_mult_seq;
`ifdef ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   last_in_cyc = 0;
  int   prev_in_cyc = 0;

  array_row_mult_seq_if bus();

  array_row_mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        n_in        = n_in + 1;
        prev_in_cyc = last_in_cyc;
        last_in_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) n_out = n_out + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    return (BYP && (a == 8'd0 || b == 8'd0)) ? 1 : 10;
  endfunction

  // Presents one operand pair and waits for out_valid; leaves the block in DONE.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat,
                        output bit to, output bit ir_high);
    int w;
    w = 0;
    to = 1'b0;
    ir_high = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      if (bus.in_ready) ir_high = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready) ir_high = 1'b1;
    if (!bus.out_valid) to = 1'b1;
    p = bus.product;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    #23;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 16'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.product, bus.busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat; bit to; bit irh;
    bus.out_ready = 1'b1;
    do_txn(8'd13, 8'd11, p, lat, to, irh);
    checks++;
    if (to || p !== 16'd143) begin
      failures++;
      $display("FAIL basic_product: got %0d (timeout=%0b), required 143", p, to);
    end
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles, required 10", lat);
    end
    checks++;
    if (irh !== 1'b0) begin
      failures++;
      $display("FAIL basic_in_ready: in_ready seen high during cycles 1-10, required low");
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_done: busy=%b in DONE, required 0", bus.busy);
    end
    release_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_accept: out_valid=%b in_ready=%b after acceptance, required 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_max();
    logic [7:0] av [2] = '{8'hFF, 8'h80};
    logic [7:0] bv [2] = '{8'hFF, 8'h80};
    logic [15:0] ev [2] = '{16'hFE01, 16'h4000};
    logic [15:0] p; int lat; bit to; bit irh;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_txn(av[i], bv[i], p, lat, to, irh);
      checks++;
      if (to || p !== ev[i]) begin
        failures++;
        $display("FAIL max_product %h*%h: got %h, required %h", av[i], bv[i], p, ev[i]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p; int lat; bit to; bit irh;
    bus.out_ready = 1'b0;
    do_txn(8'd200, 8'd100, p, lat, to, irh);
    checks++;
    if (to || p !== 16'd20000) begin
      failures++;
      $display("FAIL bp_product: got %0d, required 20000", p);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 8'd7;
      bus.b = 8'd9;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.product !== 16'd20000 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall[%0d]: out_valid=%b product=%0d in_ready=%b, required 1 20000 0",
                 i, bus.out_valid, bus.product, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_zero();
    logic [15:0] p; int lat; bit to; bit irh;
    bus.out_ready = 1'b1;
    do_txn(8'd0, 8'hA5, p, lat, to, irh);
    checks++;
    if (to || p !== 16'd0) begin
      failures++;
      $display("FAIL zero_product: got %h, required 0000", p);
    end
    checks++;
    if (lat !== exp_lat(8'd0, 8'hA5)) begin
      failures++;
      $display("FAIL zero_latency: got %0d, required %0d", lat, exp_lat(8'd0, 8'hA5));
    end
    release_out();
  endtask

  task automatic test_reset_mid_row();
    logic [15:0] p; int lat; bit to; bit irh;
    bus.out_ready = 1'b1;
    bus.a = 8'd77;
    bus.b = 8'd201;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrow_busy: busy=%b before reset, required 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 16'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrow_async_reset: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.product, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(8'd3, 8'd5, p, lat, to, irh);
    checks++;
    if (to || p !== 16'd15 || lat !== 10) begin
      failures++;
      $display("FAIL midrow_after_reset: product=%0d latency=%0d, required 15 10", p, lat);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int w;
    w = 0;
    n_in = 0;
    n_out = 0;
    bus.out_ready = 1'b1;
    bus.a = 8'd21;
    bus.b = 8'd34;
    bus.in_valid = 1'b1;
    while (n_in < 2 && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n_in < 2 || (last_in_cyc - prev_in_cyc) !== 11) begin
      failures++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d cycles, required 2 and 11",
               n_in, last_in_cyc - prev_in_cyc);
    end
    w = 0;
    while (n_out < 2 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (n_out !== 2) begin
      failures++;
      $display("FAIL b2b_outputs: got %0d outputs, required 2", n_out);
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [15:0] p, ev;
    int lat, stall;
    bit to, irh, r;
    n_in = 0;
    n_out = 0;
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) a = 8'd0;
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      ev = 16'(a) * 16'(b);
      bus.out_ready = 1'($urandom);
      do_txn(a, b, p, lat, to, irh);
      checks++;
      if (to || p !== ev || lat !== exp_lat(a, b)) begin
        failures++;
        $display("FAIL rand[%0d] %0d*%0d: product=%0d latency=%0d, required %0d %0d",
                 t, a, b, p, lat, ev, exp_lat(a, b));
      end
      stall = 0;
      forever begin
        r = bus.out_ready;
        @(posedge clk); #1;
        if (r) break;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== ev) begin
          failures++;
          $display("FAIL rand_hold[%0d]: out_valid=%b product=%0d, required 1 %0d",
                   t, bus.out_valid, bus.product, ev);
        end
        stall++;
        bus.out_ready = (stall > 6) ? 1'b1 : 1'($urandom);
      end
    end
    checks++;
    if (n_in !== 1000 || n_out !== 1000) begin
      failures++;
      $display("FAIL rand_count: accepted=%0d produced=%0d, required 1000 1000", n_in, n_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_zero();
    test_reset_mid_row();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
